// File: rtl/button_debouncer_pkg.sv
// Shared constants and helpers for the push-button debouncer.
package button_debouncer_pkg;

    // Default number of consecutive 1 ms samples a new value must hold.
    localparam int DEFAULT_STABLE_TICKS = 20;

    // Raw pin polarity selectors for BTN_ACTIVE_LOW.
    localparam bit POL_ACTIVE_LOW  = 1'b1;
    localparam bit POL_ACTIVE_HIGH = 1'b0;

    // Counter width: clog2 of the tick count, never narrower than one bit.
    function automatic int cnt_width(input int ticks);
        return (ticks <= 1) ? 1 : $clog2(ticks);
    endfunction

    // Raw pin value seen while the button is not pressed.
    function automatic logic released_raw(input bit active_low);
        return (active_low == POL_ACTIVE_LOW) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounced button: input synchronizer, stability counter, level and pulses.
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_TICKS   = DEFAULT_STABLE_TICKS,
    parameter bit BTN_ACTIVE_LOW = POL_ACTIVE_LOW
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic btn_raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int            CW       = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] TERM     = CW'(STABLE_TICKS - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic          RELEASED = released_raw(BTN_ACTIVE_LOW);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          sample_norm;

    // Synchronizer next state and pressed-high normalization of the sampled pin.
    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        sample_norm = BTN_ACTIVE_LOW ? ~sync2_q : sync2_q;
    end

    // Two-flop synchronizer; resets to the released pin value so no press appears after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RELEASED;
            sync2_q <= RELEASED;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    // Stability counter: only a full run of differing samples moves the level.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        if (sample_en) begin
            if (sample_norm == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == TERM) begin
                level_d = sample_norm;
                cnt_d   = '0;
                press_d = sample_norm;
                rel_d   = ~sample_norm;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    // Counter, level and pulse registers; pulses land in the same cycle as the level change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer sampled by the synchronized 1 kHz divided clock.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int NUM_BTN        = 4,
    parameter int STABLE_TICKS   = DEFAULT_STABLE_TICKS,
    parameter bit BTN_ACTIVE_LOW = POL_ACTIVE_LOW
) (
    input  logic               db_clk_in,
    input  logic               db_rst_n_in,
    input  logic               db_tick_clk_in,
    input  logic [NUM_BTN-1:0] db_btn_in,
    output logic               db_sample_out,
    output logic [NUM_BTN-1:0] db_btn_level_out,
    output logic [NUM_BTN-1:0] db_btn_press_out,
    output logic [NUM_BTN-1:0] db_btn_release_out
);

    logic tick_sync1_q, tick_sync1_d;
    logic tick_sync2_q, tick_sync2_d;
    logic tick_hist_q, tick_hist_d;
    logic sample_q, sample_d;

    // Tick synchronizer chain and rising-edge detect; hist trails sync2 so the strobe is one cycle wide.
    always_comb begin
        tick_sync1_d = db_tick_clk_in;
        tick_sync2_d = tick_sync1_q;
        tick_hist_d  = tick_sync2_q;
        sample_d     = tick_sync2_q & ~tick_hist_q;
    end

    // Tick synchronizer, history and registered sample strobe.
    always_ff @(posedge db_clk_in or negedge db_rst_n_in) begin
        if (!db_rst_n_in) begin
            tick_sync1_q <= 1'b0;
            tick_sync2_q <= 1'b0;
            tick_hist_q  <= 1'b0;
            sample_q     <= 1'b0;
        end else begin
            tick_sync1_q <= tick_sync1_d;
            tick_sync2_q <= tick_sync2_d;
            tick_hist_q  <= tick_hist_d;
            sample_q     <= sample_d;
        end
    end

    assign db_sample_out = sample_q;

    // One independent debounce channel per button, all sharing the sample strobe.
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        debounce_channel #(
            .STABLE_TICKS  (STABLE_TICKS),
            .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
        ) u_ch (
            .clk      (db_clk_in),
            .rst_n    (db_rst_n_in),
            .sample_en(sample_q),
            .btn_raw  (db_btn_in[g]),
            .level    (db_btn_level_out[g]),
            .press    (db_btn_press_out[g]),
            .rel      (db_btn_release_out[g])
        );
    end

endmodule
